alarm_set: RTL and testbench



---
 rtl/alarm_set.sv | 225 ++++++++++++++++++++++
 tb/tb_alarm_set.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_set.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alarm_set                                               |
// | Brief    : Push-button alarm-time entry. Buttons are synchronised  |
// |            and edge-detected; a three-state edit FSM edits a       |
// |            shadow time (with hold-to-repeat and inactivity         |
// |            timeout) and commits it when editing completes.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module alarm_set #(
  parameter int HOLD_CYC    = 8,   // must be >= RPT_CYC
  parameter int RPT_CYC     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] hr1,
  output logic [3:0] hr0,
  output logic [2:0] min1,
  output logic [3:0] min0,
  output logic [1:0] d_hr1,
  output logic [3:0] d_hr0,
  output logic [2:0] d_min1,
  output logic [3:0] d_min0,
  output logic [1:0] state
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [HW-1:0] C_HOLD    = HW'(HOLD_CYC);
  // Reloading here makes the next repeat fire RPT_CYC cycles later
  localparam logic [HW-1:0] C_RELOAD  = HW'(HOLD_CYC - RPT_CYC + 1);
  localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_SET_HR  = 2'b01,
    S_SET_MIN = 2'b10,
    S_BAD     = 2'b11
  } state_t;

  state_t        state_q;
  logic [TW-1:0] to_q;

  // bit 0 = mode, bit 1 = up, bit 2 = down
  logic [2:0] sync1_q, sync2_q, edge_q;
  logic [2:0] w_pulse;
  logic [1:0] w_rep;

  logic [1:0] hr1_q, sh_hr1_q, sh_hr1_d;
  logic [3:0] hr0_q, sh_hr0_q, sh_hr0_d;
  logic [2:0] min1_q, sh_min1_q, sh_min1_d;
  logic [3:0] min0_q, sh_min0_q, sh_min0_d;

  logic w_edit, w_mode, w_up, w_dn, w_timeout, w_leave;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= {btn_down, btn_up, btn_mode};
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign w_pulse = sync2_q & ~edge_q;

  assign w_edit    = (state_q == S_SET_HR) || (state_q == S_SET_MIN);
  assign w_mode    = w_pulse[0];
  assign w_up      = w_pulse[1] | w_rep[0];
  assign w_dn      = w_pulse[2] | w_rep[1];
  assign w_timeout = w_edit && !w_mode && !w_up && !w_dn && (to_q == C_TO_LAST);
  // Any state change this cycle: hold timers must restart from scratch
  assign w_leave   = w_mode || w_timeout || (state_q == S_BAD);

  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    logic [HW-1:0] hold_q;

    // Per-step-button hold timer: counts from the first step, fires repeats
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q <= '0;
      end else if (!w_edit || w_leave || !sync2_q[gi+1]) begin
        hold_q <= '0;
      end else if (w_pulse[gi+1]) begin
        hold_q <= HW'(1);
      end else if (hold_q == C_HOLD) begin
        hold_q <= C_RELOAD;
      end else if (hold_q != '0) begin
        hold_q <= hold_q + HW'(1);
      end
    end

    assign w_rep[gi] = w_edit && sync2_q[gi+1] && (hold_q == C_HOLD);
  end

  // Next shadow value: BCD mod-24 hour or mod-60 minute step, no carry between
  always_comb begin
    sh_hr1_d  = sh_hr1_q;
    sh_hr0_d  = sh_hr0_q;
    sh_min1_d = sh_min1_q;
    sh_min0_d = sh_min0_q;
    if (w_up && !w_dn) begin
      if (state_q == S_SET_HR) begin
        if (sh_hr1_q == 2'd2 && sh_hr0_q == 4'd3) begin
          sh_hr1_d = 2'd0;
          sh_hr0_d = 4'd0;
        end else if (sh_hr0_q == 4'd9) begin
          sh_hr1_d = sh_hr1_q + 2'd1;
          sh_hr0_d = 4'd0;
        end else begin
          sh_hr0_d = sh_hr0_q + 4'd1;
        end
      end else if (state_q == S_SET_MIN) begin
        if (sh_min0_q == 4'd9) begin
          sh_min0_d = 4'd0;
          sh_min1_d = (sh_min1_q == 3'd5) ? 3'd0 : sh_min1_q + 3'd1;
        end else begin
          sh_min0_d = sh_min0_q + 4'd1;
        end
      end
    end else if (w_dn && !w_up) begin
      if (state_q == S_SET_HR) begin
        if (sh_hr1_q == 2'd0 && sh_hr0_q == 4'd0) begin
          sh_hr1_d = 2'd2;
          sh_hr0_d = 4'd3;
        end else if (sh_hr0_q == 4'd0) begin
          sh_hr1_d = sh_hr1_q - 2'd1;
          sh_hr0_d = 4'd9;
        end else begin
          sh_hr0_d = sh_hr0_q - 4'd1;
        end
      end else if (state_q == S_SET_MIN) begin
        if (sh_min0_q == 4'd0) begin
          sh_min0_d = 4'd9;
          sh_min1_d = (sh_min1_q == 3'd0) ? 3'd5 : sh_min1_q - 3'd1;
        end else begin
          sh_min0_d = sh_min0_q - 4'd1;
        end
      end
    end
  end

  // Edit FSM: mode transitions, timeout, shadow load/update and commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      to_q      <= '0;
      hr1_q     <= 2'd0;
      hr0_q     <= 4'd7;
      min1_q    <= 3'd0;
      min0_q    <= 4'd0;
      sh_hr1_q  <= 2'd0;
      sh_hr0_q  <= 4'd7;
      sh_min1_q <= 3'd0;
      sh_min0_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          to_q <= '0;
          if (w_mode) begin
            state_q   <= S_SET_HR;
            sh_hr1_q  <= hr1_q;
            sh_hr0_q  <= hr0_q;
            sh_min1_q <= min1_q;
            sh_min0_q <= min0_q;
          end
        end
        S_SET_HR: begin
          if (w_mode) begin
            state_q <= S_SET_MIN;
            to_q    <= '0;
          end else if (w_timeout) begin
            state_q <= S_IDLE;
            to_q    <= '0;
          end else begin
            sh_hr1_q <= sh_hr1_d;
            sh_hr0_q <= sh_hr0_d;
            to_q     <= (w_up || w_dn) ? '0 : to_q + TW'(1);
          end
        end
        S_SET_MIN: begin
          if (w_mode) begin
            state_q <= S_IDLE;
            to_q    <= '0;
            hr1_q   <= sh_hr1_q;
            hr0_q   <= sh_hr0_q;
            min1_q  <= sh_min1_q;
            min0_q  <= sh_min0_q;
          end else if (w_timeout) begin
            state_q <= S_IDLE;
            to_q    <= '0;
          end else begin
            sh_min1_q <= sh_min1_d;
            sh_min0_q <= sh_min0_d;
            to_q      <= (w_up || w_dn) ? '0 : to_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          to_q    <= '0;
        end
      endcase
    end
  end

  assign state  = state_q;
  assign hr1    = hr1_q;
  assign hr0    = hr0_q;
  assign min1   = min1_q;
  assign min0   = min0_q;
  assign d_hr1  = (state_q == S_IDLE) ? hr1_q  : sh_hr1_q;
  assign d_hr0  = (state_q == S_IDLE) ? hr0_q  : sh_hr0_q;
  assign d_min1 = (state_q == S_IDLE) ? min1_q : sh_min1_q;
  assign d_min0 = (state_q == S_IDLE) ? min0_q : sh_min0_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_set.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_alarm_set                                            |
// | Brief    : Scoreboard bench for alarm_set against a minute-level   |
// |            reference model of the alarm-entry behaviour.           |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_alarm_set;

  localparam int HOLD = 8;
  localparam int RPT  = 4;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [1:0] hr1, d_hr1, state;
  logic [3:0] hr0, min0, d_hr0, d_min0;
  logic [2:0] min1, d_min1;

  alarm_set #(.HOLD_CYC(HOLD), .RPT_CYC(RPT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0),
    .d_hr1(d_hr1), .d_hr0(d_hr0), .d_min1(d_min1), .d_min0(d_min0),
    .state(state)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [27:0] act;
  assign act = {state, hr1, hr0, min1, min0, d_hr1, d_hr0, d_min1, d_min0};

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int unsigned stamp;
    logic [27:0] val;
    string       name;
  } exp_t;
  exp_t q[$];

  // Reference model: mode 0/1/2, times as plain hour/minute integers
  int m_st, c_h, c_m, s_h, s_m;

  function automatic logic [12:0] bcd(input int h, input int m);
    logic [1:0] a; logic [3:0] b; logic [2:0] c; logic [3:0] d;
    a = 2'(h / 10); b = 4'(h % 10); c = 3'(m / 10); d = 4'(m % 10);
    return {a, b, c, d};
  endfunction

  function automatic logic [27:0] model_tuple();
    logic [1:0] st;
    st = 2'(m_st);
    return {st, bcd(c_h, c_m), (m_st == 0) ? bcd(c_h, c_m) : bcd(s_h, s_m)};
  endfunction

  function automatic string fmt(input logic [27:0] v);
    return $sformatf("state=%0d committed=%0d%0d:%0d%0d display=%0d%0d:%0d%0d",
                     v[27:26], v[25:24], v[23:20], v[19:17], v[16:13],
                     v[12:11], v[10:7], v[6:4], v[3:0]);
  endfunction

  task automatic model_reset();
    m_st = 0; c_h = 7; c_m = 0; s_h = 7; s_m = 0;
  endtask

  task automatic apply_mode();
    case (m_st)
      0: begin s_h = c_h; s_m = c_m; m_st = 1; end
      1: m_st = 2;
      default: begin c_h = s_h; c_m = s_m; m_st = 0; end
    endcase
  endtask

  task automatic apply_steps(input int n);
    if (m_st == 1) s_h = (((s_h + n) % 24) + 24) % 24;
    else if (m_st == 2) s_m = (((s_m + n) % 60) + 60) % 60;
  endtask

  task automatic check(input string nm, input logic [27:0] a, input logic [27:0] e);
    n_vec++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", nm, fmt(a), fmt(e));
    end
  endtask

  task automatic expect_at(input int unsigned st, input string nm);
    exp_t e;
    e.stamp = st; e.val = model_tuple(); e.name = nm;
    q.push_back(e);
  endtask

  // Press a button combination for 'hold' clock edges, then release and settle
  task automatic press(input bit m, input bit u, input bit d, input int hold, input string nm);
    int unsigned c0;
    int k, n;
    c0 = cyc;
    if (m) begin
      expect_at(c0 + 2, {nm, "_before"});
      apply_mode();
      expect_at(c0 + 3, {nm, "_edge"});
    end else if (u ^ d) begin
      k = hold - 1;
      n = (k < HOLD) ? 1 : 2 + (k - HOLD) / RPT;
      apply_steps(u ? n : -n);
    end
    btn_mode = m; btn_up = u; btn_down = d;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(negedge clk);
    expect_at(cyc + 1, nm);
  endtask

  task automatic idle(input int n, input bit tmo, input string nm);
    repeat (n) @(negedge clk);
    if (tmo) m_st = 0;
    expect_at(cyc + 1, nm);
  endtask

  // Monitor: compare every scheduled expectation at its cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].stamp <= cyc) begin
        e = q.pop_front();
        if (e.stamp < cyc) begin
          n_vec++;
          n_fail++;
          $display("FAIL %s: check slot %0d missed at cycle %0d", e.name, e.stamp, cyc);
        end else begin
          check(e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    bit last_idle;
    int r, guard;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", act, model_tuple());
    rst = 1'b0;
    expect_at(cyc + 1, "after_reset");

    press(0, 1, 0, 1, "idle_up_ignored");

    // Enter edit, 17 ups wraps 07 -> 00, then minute down and commit
    press(1, 0, 0, 1, "enter_set_hr");
    for (int i = 0; i < 17; i++) press(0, 1, 0, 1, "hr_up");
    press(1, 0, 0, 1, "enter_set_min");
    press(0, 0, 1, 1, "min_00_down");
    press(1, 0, 0, 1, "commit_0059");

    // Hour 09->10, 20->19; minute 59->00, 10->09
    press(1, 0, 0, 2, "edit2");
    for (int i = 0; i < 9; i++) press(0, 1, 0, 1, "hr_up_to_09");
    press(0, 1, 0, 1, "hr_09_10");
    for (int i = 0; i < 10; i++) press(0, 1, 0, 1, "hr_up_to_20");
    press(0, 0, 1, 1, "hr_20_19");
    press(1, 0, 0, 1, "edit2_min");
    press(0, 1, 0, 1, "min_59_00");
    for (int i = 0; i < 10; i++) press(0, 1, 0, 1, "min_up_to_10");
    press(0, 0, 1, 1, "min_10_09");
    press(1, 0, 0, 1, "commit_1909");

    // Auto-repeat from minute 00
    press(1, 0, 0, 1, "rpt_hr");
    press(1, 0, 0, 1, "rpt_min");
    for (int i = 0; i < 9; i++) press(0, 0, 1, 1, "min_down_to_00");
    press(0, 1, 0, HOLD + 3 * RPT + 2, "auto_repeat_5");
    press(1, 0, 0, 1, "commit_1905");

    // Timeout abandons the edit
    press(1, 0, 0, 1, "tmo_enter");
    press(0, 1, 0, 1, "tmo_up1");
    press(0, 1, 0, 1, "tmo_up2");
    idle(TMO + 16, 1'b1, "timeout_idle");

    // Simultaneous inputs
    press(1, 0, 0, 1, "sim_enter");
    press(1, 1, 0, 1, "mode_plus_up");
    idle(40, 1'b0, "sim_wait1");
    press(0, 1, 1, 1, "up_plus_down");
    idle(40, 1'b0, "timeout_restarted");

    // Asynchronous reset mid-SET_MIN
    press(0, 1, 0, 1, "pre_rst_up");
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check("async_reset", act, model_tuple());
    @(negedge clk);
    rst = 1'b0;
    expect_at(cyc + 1, "post_reset");

    // Randomised sequence
    last_idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (!last_idle && r >= 90) begin
        if (r < 97) idle($urandom_range(1, 20), 1'b0, "rnd_idle");
        else idle(TMO + 16, 1'b1, "rnd_timeout");
        last_idle = 1'b1;
      end else begin
        last_idle = 1'b0;
        if (r < 20)      press(1, 0, 0, $urandom_range(1, 4), "rnd_mode");
        else if (r < 48) press(0, 1, 0, $urandom_range(1, 25), "rnd_up");
        else if (r < 76) press(0, 0, 1, $urandom_range(1, 25), "rnd_down");
        else if (r < 83) press(0, 1, 1, $urandom_range(1, 25), "rnd_updown");
        else             press(1, r[0], ~r[0], $urandom_range(1, 4), "rnd_mode_step");
      end
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    while (q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: expectation never checked (slot %0d)", q[0].name, q[0].stamp);
      void'(q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
